// File: rtl/sdram_sched_pkg.sv
// Shared types and widths for the SDRAM client scheduler and its helpers.
package sdram_sched_pkg;
  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP,
    ST_REF,
    ST_REF_WAIT
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr wins, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);
  int               cand;
  logic [IDX_W-1:0] ci;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    ci        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      ci = IDX_W'(cand);
      if (!valid && req[ci]) begin
        valid     = 1'b1;
        grant[ci] = 1'b1;
        grant_idx = ci;
      end
    end
  end
endmodule

// File: rtl/sdram_client_sched.sv
// Shares one SDRAM controller channel between clients round-robin and owns auto-refresh timing.
//  state        | meaning
//  ST_IDLE      | pick refresh or next client
//  ST_ISSUE     | strobe rises with latched request
//  ST_WAIT_BUSY | strobe held until controller reports busy
//  ST_WAIT_DONE | strobe held; busy falling completes and acks
//  ST_GAP       | strobes low one cycle so the next access is a fresh edge
//  ST_REF       | one-cycle refresh pulse
//  ST_REF_WAIT  | hold off clients for one controller cycle
module sdram_client_sched
  import sdram_sched_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int REF_INTERVAL = 660,
  parameter int REF_MAX_DEBT = 8,
  parameter int CTRL_CYCLE   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CLIENTS-1:0]              cl_req,
  input  logic [NUM_CLIENTS-1:0]              cl_we,
  input  logic [NUM_CLIENTS*SDRAM_ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*SDRAM_DATA_W-1:0] cl_din,
  output logic [NUM_CLIENTS-1:0]              cl_ack,
  output logic [SDRAM_DATA_W-1:0]             cl_dout,
  output logic [SDRAM_ADDR_W-1:0]             sd_addr,
  output logic                                sd_rd,
  output logic                                sd_wr,
  output logic [SDRAM_DATA_W-1:0]             sd_din,
  input  logic [SDRAM_DATA_W-1:0]             sd_dout,
  input  logic                                sd_busy,
  output logic                                sd_refresh,
  output logic [3:0]                          ref_debt,
  output logic                                ref_overrun
);
  localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int REF_TW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int HOLD_W = (CTRL_CYCLE > 2) ? $clog2(CTRL_CYCLE) : 1;
  localparam logic [REF_TW-1:0] REF_LOAD  = REF_TW'(REF_INTERVAL - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CTRL_CYCLE - 1);
  localparam logic [3:0]        DEBT_MAX  = 4'(REF_MAX_DEBT);

  sched_state_t            state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr, arb_idx;
  logic [NUM_CLIENTS-1:0]  arb_grant, gnt_q;
  logic                    arb_valid, take, done, strobe, ref_tick, ref_issue;
  logic [SDRAM_ADDR_W-1:0] addr_q;
  logic [SDRAM_DATA_W-1:0] din_q, dout_q;
  logic                    we_q;
  logic [REF_TW-1:0]       ref_timer;
  logic [HOLD_W-1:0]       hold_cnt;
  int                      sel;

  rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
    .req      (cl_req),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .valid    (arb_valid)
  );

  assign ref_tick  = (ref_timer == '0);
  assign ref_issue = (state == ST_REF);
  assign done      = (state == ST_WAIT_DONE) && !sd_busy;
  assign take      = (state == ST_IDLE) && (ref_debt != DEBT_MAX) && arb_valid;
  assign sel       = int'(arb_idx);

  // Timer reloads on the tick; a same-cycle tick and issue leave the debt alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_timer   <= REF_LOAD;
      ref_debt    <= '0;
      ref_overrun <= 1'b0;
    end else begin
      ref_timer <= ref_tick ? REF_LOAD : ref_timer - REF_TW'(1);
      if (ref_tick && !ref_issue) begin
        if (ref_debt == DEBT_MAX) ref_overrun <= 1'b1;
        else                      ref_debt    <= ref_debt + 4'd1;
      end else if (ref_issue && !ref_tick) begin
        ref_debt <= ref_debt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= IDX_W'(NUM_CLIENTS - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      dout_q   <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        rr_ptr <= arb_idx;
        gnt_q  <= arb_grant;
        addr_q <= cl_addr[sel*SDRAM_ADDR_W +: SDRAM_ADDR_W];
        din_q  <= cl_din[sel*SDRAM_DATA_W +: SDRAM_DATA_W];
        we_q   <= cl_we[arb_idx];
      end
      if (done && !we_q) dout_q <= sd_dout;
      if (state == ST_REF)                               hold_cnt <= HOLD_LOAD;
      else if (state == ST_REF_WAIT && hold_cnt != '0)   hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Outputs are gated by reset so an aborted access drops its strobe at once.
  always_comb begin
    state_nxt  = state;
    strobe     = 1'b0;
    cl_ack     = '0;
    cl_dout    = dout_q;
    sd_refresh = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ref_debt == DEBT_MAX) state_nxt = ST_REF;
        else if (arb_valid)       state_nxt = ST_ISSUE;
        else if (ref_debt != '0)  state_nxt = ST_REF;
      end
      ST_ISSUE: begin
        strobe    = 1'b1;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        strobe = 1'b1;
        if (sd_busy) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        strobe = sd_busy;
        if (!sd_busy) state_nxt = ST_GAP;
      end
      ST_GAP:      state_nxt = ST_IDLE;
      ST_REF: begin
        sd_refresh = !reset;
        state_nxt  = ST_REF_WAIT;
      end
      ST_REF_WAIT: if (hold_cnt == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (done && !reset) begin
      cl_ack = gnt_q;
      if (!we_q) cl_dout = sd_dout;
    end
    strobe  = strobe && !reset;
    sd_rd   = strobe && !we_q;
    sd_wr   = strobe && we_q;
    sd_addr = addr_q;
    sd_din  = din_q;
  end
endmodule
